// File: rtl/sqrt_nonrestoring_param.sv
// Iterative non-restoring square root: one root bit per cycle, then a fix-up
// cycle that restores a non-negative remainder and optionally rounds the root.
module sqrt_nonrestoring_param #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int ROUND = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   x_in,
    output logic [WIDTH/2-1:0] sqrt_out,
    output logic [WIDTH/2:0]   rem_out,
    output logic               busy,
    output logic               done
);
    localparam int OUT_W = WIDTH / 2;
    localparam int RW    = OUT_W + 2;
    localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [CW-1:0] LAST = CW'(OUT_W - 1);

    if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
        $error("sqrt_nonrestoring_param: WIDTH must be even and >= 4");
    end
    if ((FRAC % 2) != 0 || FRAC > WIDTH || FRAC < 0) begin : g_bad_frac
        $error("sqrt_nonrestoring_param: FRAC must be even and <= WIDTH");
    end
    if (ROUND != 0 && ROUND != 1) begin : g_bad_round
        $error("sqrt_nonrestoring_param: ROUND must be 0 or 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        FINAL = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  x_q, x_d;
    logic [OUT_W-1:0]  q_q, q_d;
    logic [RW-1:0]     r_q, r_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [OUT_W-1:0]  sqrt_q, sqrt_d;
    logic [OUT_W:0]    rem_q, rem_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [RW-1:0]     r_shift, r_iter, r_fix;
    logic [OUT_W-1:0]  q_iter, sqrt_fin;
    logic              round_up;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ITER;
            ITER:    if (cnt_q == LAST) state_d = FINAL;
            FINAL:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // R is two's complement in RW bits; its MSB is the sign. Intermediate
    // overflow of the shift wraps harmlessly because every true R' fits in RW.
    always_comb begin
        r_shift = {r_q[RW-3:0], x_q[WIDTH-1 -: 2]};
        if (!r_q[RW-1]) begin
            r_iter = r_shift - {q_q, 2'b01};
        end else begin
            r_iter = r_shift + {q_q, 2'b11};
        end
        q_iter = {q_q[OUT_W-2:0], ~r_iter[RW-1]};

        r_fix    = r_q[RW-1] ? (r_q + {1'b0, q_q, 1'b1}) : r_q;
        round_up = (ROUND != 0) && (r_fix[OUT_W:0] > {1'b0, q_q});
        sqrt_fin = (round_up && !(&q_q)) ? (q_q + 1'b1) : q_q;
    end

    // Datapath / output next-state
    always_comb begin
        x_d    = x_q;
        q_d    = q_q;
        r_d    = r_q;
        cnt_d  = cnt_q;
        sqrt_d = sqrt_q;
        rem_d  = rem_q;
        busy_d = busy_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d    = x_in;
                    q_d    = '0;
                    r_d    = '0;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                end
            end
            ITER: begin
                x_d   = {x_q[WIDTH-3:0], 2'b00};
                r_d   = r_iter;
                q_d   = q_iter;
                cnt_d = cnt_q + 1'b1;
            end
            FINAL: begin
                r_d    = r_fix;
                sqrt_d = sqrt_fin;
                rem_d  = r_fix[OUT_W:0];
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q    <= '0;
            q_q    <= '0;
            r_q    <= '0;
            cnt_q  <= '0;
            sqrt_q <= '0;
            rem_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            q_q    <= q_d;
            r_q    <= r_d;
            cnt_q  <= cnt_d;
            sqrt_q <= sqrt_d;
            rem_q  <= rem_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign sqrt_out = sqrt_q;
    assign rem_out  = rem_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_sqrt_nonrestoring_param.sv
// Bench for sqrt_nonrestoring_param: three instances (truncate, round, 24-bit)
// checked every cycle against an arithmetic square-root model.
module tb_sqrt_nonrestoring_param;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0]        st;
    logic [2:0][31:0]  xi;
    logic [7:0]        s0, s1;
    logic [8:0]        r0, r1;
    logic [11:0]       s2;
    logic [12:0]       r2;
    logic [2:0]        bsy, dn;
    logic [2:0][31:0]  sq, rm;

    sqrt_nonrestoring_param #(.WIDTH(16), .FRAC(8), .ROUND(0)) u_t (
        .clk(clk), .rst(rst), .start(st[0]), .x_in(xi[0][15:0]),
        .sqrt_out(s0), .rem_out(r0), .busy(bsy[0]), .done(dn[0]));
    sqrt_nonrestoring_param #(.WIDTH(16), .FRAC(8), .ROUND(1)) u_r (
        .clk(clk), .rst(rst), .start(st[1]), .x_in(xi[1][15:0]),
        .sqrt_out(s1), .rem_out(r1), .busy(bsy[1]), .done(dn[1]));
    sqrt_nonrestoring_param #(.WIDTH(24), .FRAC(16), .ROUND(0)) u_w (
        .clk(clk), .rst(rst), .start(st[2]), .x_in(xi[2][23:0]),
        .sqrt_out(s2), .rem_out(r2), .busy(bsy[2]), .done(dn[2]));

    assign sq[0] = {24'b0, s0};
    assign sq[1] = {24'b0, s1};
    assign sq[2] = {20'b0, s2};
    assign rm[0] = {23'b0, r0};
    assign rm[1] = {23'b0, r1};
    assign rm[2] = {19'b0, r2};

    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    function automatic int ow(input int i);
        return (i == 2) ? 12 : 8;
    endfunction

    function automatic longint isqrt(input longint x);
        longint q = 0;
        while ((q + 1) * (q + 1) <= x) q++;
        return q;
    endfunction

    // Nearest integer to sqrt(x): round up when (q+0.5)^2 <= x, clamp to range.
    function automatic longint exp_sqrt(input int i, input longint x);
        longint q = isqrt(x);
        longint mx = (longint'(1) << ow(i)) - 1;
        if (i == 1 && (2 * q + 1) * (2 * q + 1) <= 4 * x) q++;
        if (q > mx) q = mx;
        return q;
    endfunction

    // Model: an accepted start yields a result OUT_W+1 edges later; outputs hold otherwise.
    bit     pend   [3];
    longint due    [3];
    longint mx_    [3];
    longint last_s [3];
    longint last_r [3];
    bit     exp_dn [3];

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
            exp_dn[i] = 1'b0;
            if (!rst) begin
                pend[i]   = 1'b0;
                last_s[i] = 0;
                last_r[i] = 0;
            end else if (pend[i] && cyc == due[i]) begin
                pend[i]   = 1'b0;
                exp_dn[i] = 1'b1;
                last_s[i] = exp_sqrt(i, mx_[i]);
                last_r[i] = mx_[i] - isqrt(mx_[i]) * isqrt(mx_[i]);
            end else if (!pend[i] && st[i]) begin
                pend[i] = 1'b1;
                due[i]  = cyc + ow(i) + 1;
                mx_[i]  = longint'(xi[i]) & ((longint'(1) << (2 * ow(i))) - 1);
            end
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("d%0d.done@%0d", i, cyc), 64'(dn[i]), 64'(exp_dn[i]));
            chk($sformatf("d%0d.busy@%0d", i, cyc), 64'(bsy[i]), 64'(pend[i]));
            chk($sformatf("d%0d.sqrt@%0d", i, cyc), 64'(sq[i]), last_s[i]);
            chk($sformatf("d%0d.rem@%0d", i, cyc), 64'(rm[i]), last_r[i]);
        end
    end

    task automatic launch(input logic [2:0] m, input longint a, input longint b,
                          input longint c, output longint k);
        @(negedge clk);
        st = m;
        xi[0] = 32'(a);
        xi[1] = 32'(b);
        xi[2] = 32'(c);
        k = cyc + 1;
        @(negedge clk);
        st = '0;
    endtask

    task automatic wait_done(input int i, output longint c);
        int n = 0;
        while (!dn[i] && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("d%0d.timeout", i), 64'(dn[i]), 64'd1);
        c = cyc;
    endtask

    initial begin
        longint k, c;
        int     npulse;
        longint a [3];
        rst = 1'b0;
        st  = '0;
        xi  = '0;
        repeat (2) @(negedge clk);
        chk("reset_sqrt", 64'(sq[0]), 0);
        chk("reset_busy", 64'(bsy), 0);
        rst = 1'b1;

        chk("pin_isqrt512", isqrt(512), 22);
        chk("pin_round512", exp_sqrt(1, 512), 23);
        chk("pin_sat", exp_sqrt(1, 'hFFFF), 255);
        chk("pin_w24", isqrt('h20000), 362);

        launch(3'b001, 'h0100, 0, 0, k);
        wait_done(0, c);
        chk("t1_lat", c - k, 9);
        chk("t1_sqrt", 64'(s0), 'h10);
        chk("t1_rem", 64'(r0), 0);

        launch(3'b001, 'h1000, 0, 0, k);
        wait_done(0, c);
        chk("t2a_sqrt", 64'(s0), 'h40);
        chk("t2a_rem", 64'(r0), 0);
        st[0] = 1'b1;
        xi[0] = 'h0400;
        k = cyc + 1;
        @(negedge clk);
        st[0] = 1'b0;
        wait_done(0, c);
        chk("t2b_lat", c - k, 9);
        chk("t2b_sqrt", 64'(s0), 'h20);
        chk("t2b_rem", 64'(r0), 0);

        launch(3'b011, 'h0200, 'h0200, 0, k);
        wait_done(0, c);
        chk("t3_trunc_sqrt", 64'(s0), 'h16);
        chk("t3_trunc_rem", 64'(r0), 28);
        chk("t3_round_sqrt", 64'(s1), 'h17);
        chk("t3_round_rem", 64'(r1), 28);

        launch(3'b011, 'hFFFF, 'hFFFF, 0, k);
        wait_done(0, c);
        chk("t4_trunc_sqrt", 64'(s0), 'hFF);
        chk("t4_trunc_rem", 64'(r0), 510);
        chk("t4_sat_sqrt", 64'(s1), 'hFF);
        chk("t4_sat_rem", 64'(r1), 510);
        launch(3'b001, 0, 0, 0, k);
        wait_done(0, c);
        chk("t4_zero_sqrt", 64'(s0), 0);
        chk("t4_zero_rem", 64'(r0), 0);

        launch(3'b001, 'h0900, 0, 0, k);
        repeat (3) @(negedge clk);
        st[0] = 1'b1;
        xi[0] = 'h0100;
        @(negedge clk);
        st[0] = 1'b0;
        wait_done(0, c);
        chk("t5_ignore_sqrt", 64'(s0), 'h30);

        launch(3'b001, 'h1000, 0, 0, k);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_rst_sqrt", 64'(s0), 0);
        chk("t5_rst_rem", 64'(r0), 0);
        chk("t5_rst_busy", 64'(bsy[0]), 0);
        chk("t5_rst_done", 64'(dn[0]), 0);
        @(negedge clk);
        rst = 1'b1;
        npulse = 0;
        repeat (15) begin
            @(negedge clk);
            if (dn[0]) npulse++;
        end
        chk("t5_no_done", 64'(npulse), 0);
        launch(3'b001, 'h0400, 0, 0, k);
        wait_done(0, c);
        chk("t5_after_sqrt", 64'(s0), 'h20);

        launch(3'b100, 0, 0, 'h020000, k);
        wait_done(2, c);
        chk("t6_lat", c - k, 13);
        chk("t6_sqrt", 64'(s2), 'h16A);
        chk("t6_rem", 64'(r2), 28);

        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < 3; i++) begin
                longint mask = (longint'(1) << (2 * ow(i))) - 1;
                case ($urandom_range(0, 4))
                    0:       a[i] = 0;
                    1:       a[i] = mask;
                    2:       a[i] = (longint'($urandom_range(0, (1 << ow(i)) - 1)) ** 2) & mask;
                    default: a[i] = longint'($urandom()) & mask;
                endcase
            end
            launch(3'b111, a[0], a[1], a[2], k);
            if ($urandom_range(0, 1) == 1) begin
                repeat (2) @(negedge clk);
                st = 3'b111;
                xi[0] = $urandom();
                xi[1] = $urandom();
                xi[2] = $urandom();
                @(negedge clk);
                st = '0;
            end
            wait_done(2, c);
            @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
